// File: rtl/rah_tx_gearbox.sv
// rtl/rah_tx_gearbox.sv - packs DATA_WIDTH-bit RAH words densely into MIPI_WIDTH-bit TX beats with flush on in_last.
// Optional stall-stability checker on err: define RAH_TX_GEARBOX_ERR_EN.
module rah_tx_gearbox #(
  parameter int DATA_WIDTH = 48,
  parameter int MIPI_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [MIPI_WIDTH-1:0] out_data,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  err
);

  localparam int D  = DATA_WIDTH / 16;
  localparam int M  = MIPI_WIDTH / 16;
  localparam int N  = M + 2 * D;
  localparam int AW = N * 16;
  localparam int CW = $clog2(N + 1);

  localparam logic [CW-1:0] C_M   = CW'(M);
  localparam logic [CW-1:0] C_D   = CW'(D);
  localparam logic [CW-1:0] C_RDY = CW'(M + D);

  logic [AW-1:0]         r_acc;
  logic [CW-1:0]         r_cnt;
  logic                  r_flush;
  logic                  r_out_valid;
  logic [MIPI_WIDTH-1:0] r_out_data;
  logic                  r_out_last;

  logic                  w_in_ready;
  logic                  w_accept;
  logic                  w_free;
  logic                  w_pop;
  logic [CW-1:0]         w_take;
  logic [CW-1:0]         w_cnt_pop;
  logic [CW-1:0]         w_cnt_nxt;
  logic [AW-1:0]         w_acc_pop;
  logic [AW-1:0]         w_acc_nxt;
  logic [AW-1:0]         w_push_word;
  logic [CW+3:0]         w_push_off;
  logic [MIPI_WIDTH-1:0] w_beat;
  logic                  w_beat_last;

  // in_ready depends on registers only, so out_ready never reaches it combinationally
  always_comb begin
    w_in_ready = (r_cnt <= C_RDY) && !r_flush;
    w_accept   = in_valid && w_in_ready;
    w_free     = !r_out_valid || out_ready;
    w_pop      = w_free && ((r_cnt >= C_M) || (r_flush && (r_cnt != '0)));
  end

  always_comb begin
    w_beat = '0;
    for (int u = 0; u < M; u++) begin
      if (CW'(u) < r_cnt) begin
        w_beat[u*16 +: 16] = r_acc[u*16 +: 16];
      end
    end
    w_beat_last = r_flush && (r_cnt <= C_M);
  end

  // Pop first, then append the accepted word right above whatever remains
  always_comb begin
    w_take      = (r_cnt >= C_M) ? C_M : r_cnt;
    w_cnt_pop   = w_pop ? (r_cnt - w_take) : r_cnt;
    w_acc_pop   = w_pop ? (r_acc >> MIPI_WIDTH) : r_acc;
    w_push_word = {{(AW - DATA_WIDTH){1'b0}}, in_data};
    w_push_off  = {w_cnt_pop, 4'b0000};
    w_acc_nxt   = w_acc_pop;
    w_cnt_nxt   = w_cnt_pop;
    if (w_accept) begin
      w_acc_nxt = w_acc_pop | (w_push_word << w_push_off);
      w_cnt_nxt = w_cnt_pop + C_D;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_flush     <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else begin
      r_acc <= w_acc_nxt;
      r_cnt <= w_cnt_nxt;
      if (w_pop) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_beat;
        r_out_last  <= w_beat_last;
      end else if (w_free) begin
        r_out_valid <= 1'b0;
      end
      if (w_pop && w_beat_last) begin
        r_flush <= 1'b0;
      end else if (w_accept && in_last) begin
        r_flush <= 1'b1;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;

`ifdef RAH_TX_GEARBOX_ERR_EN
  logic                  r_stall;
  logic [DATA_WIDTH-1:0] r_hold_data;
  logic                  r_hold_last;
  logic                  r_err;

  // A stalled offer must be held unchanged until it is accepted
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_stall     <= 1'b0;
      r_hold_data <= '0;
      r_hold_last <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_stall     <= in_valid && !w_in_ready;
      r_hold_data <= in_data;
      r_hold_last <= in_last;
      if (r_stall && (!in_valid || (in_data != r_hold_data) || (in_last != r_hold_last))) begin
        r_err <= 1'b1;
      end
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_rah_tx_gearbox.sv
// tb/tb_rah_tx_gearbox.sv - scoreboard bench for rah_tx_gearbox.
module tb_rah_tx_gearbox;
  localparam int DW = 48;
  localparam int MW = 64;

  logic          clk = 1'b0;
  logic          rstn;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          in_ready;
  logic          out_valid;
  logic [MW-1:0] out_data;
  logic          out_last;
  logic          out_ready;
  logic          err;

  int n_total  = 0;
  int n_bad    = 0;
  int n_beats  = 0;
  int n_stalls = 0;

  logic [15:0]   uq[$];
  logic [MW:0]   exp_q[$];
  logic [MW:0]   got_q[$];
  logic          hold_v = 1'b0;
  logic [MW-1:0] hold_d;
  logic          hold_l;
  logic [MW:0]   e;
  logic          low_seen;

  logic [DW-1:0] pkt[4] = '{48'h0000_1111_2222, 48'h3333_4444_5555,
                            48'h6666_7777_8888, 48'h9999_AAAA_BBBB};
  logic [MW:0]   pkt_exp[3] = '{{1'b0, 64'h5555_0000_1111_2222},
                                {1'b0, 64'h7777_8888_3333_4444},
                                {1'b1, 64'h9999_AAAA_BBBB_6666}};

  always #5 clk = ~clk;

  rah_tx_gearbox #(.DATA_WIDTH(DW), .MIPI_WIDTH(MW)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .err(err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[DW-1:0];
  endfunction

  // Reference packer: a flat queue of 16-bit units cut into 4-unit beats
  task automatic model_push(input logic [DW-1:0] d, input logic l);
    logic [MW-1:0] b;
    logic          bl;
    for (int u = 0; u < DW/16; u++) uq.push_back(d[u*16 +: 16]);
    while (uq.size() >= MW/16 || (l && uq.size() > 0)) begin
      b  = '0;
      bl = l && (uq.size() <= MW/16);
      for (int u = 0; u < MW/16; u++) begin
        if (uq.size() > 0) b[u*16 +: 16] = uq.pop_front();
      end
      exp_q.push_back({bl, b});
    end
  endtask

  task automatic send(input logic [DW-1:0] d, input logic l);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(negedge clk);
    if (!in_ready) n_stalls++;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("send_timeout", 0, 1);
    else model_push(d, l);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) chk("drain_timeout", 0, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    uq.delete();
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (!rstn) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, hold_d);
        chk("hold_last", out_last, hold_l);
      end
      hold_v = out_valid && !out_ready;
      hold_d = out_data;
      hold_l = out_last;
      if (out_valid && out_ready) begin
        n_beats++;
        got_q.push_back({out_last, out_data});
        if (exp_q.size() == 0) begin
          chk("beat_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", out_data, e[MW-1:0]);
          chk("beat_last", out_last, e[MW]);
        end
      end
    end
  end

  initial begin
    rstn = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_err", err, 0);
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", in_ready, 1);

    got_q.delete();
    for (int i = 0; i < 4; i++) send(pkt[i], i == 3);
    drain();
    chk("t2_nbeats", got_q.size(), 3);
    for (int i = 0; i < 3 && i < got_q.size(); i++) chk("t2_beat", got_q[i], pkt_exp[i]);

    got_q.delete();
    send(48'hDEAD_BEEF_CAFE, 1'b1);
    chk("t3_rdy_low", in_ready, 0);
    @(posedge clk); #1;
    chk("t3_valid", out_valid, 1);
    chk("t3_data", out_data, 64'h0000_DEAD_BEEF_CAFE);
    chk("t3_last", out_last, 1);
    chk("t3_rdy_back", in_ready, 1);
    drain();

    n_stalls = 0;
    n_beats  = 0;
    for (int i = 0; i < 1000; i++) send(rnd(), i == 999);
    drain();
    chk("t4_stalls", n_stalls, 0);
    chk("t4_beats", n_beats, 750);

    low_seen = 1'b0;
    fork
      begin
        for (int i = 0; i < 60; i++) send(rnd(), i == 59);
      end
      begin
        repeat (15) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (10) begin
          @(negedge clk);
          if (!in_ready) low_seen = 1'b1;
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("t5_ready_fell", low_seen, 1);

    for (int i = 0; i < 3; i++) send(pkt[i], 1'b0);
    chk("t6_pre_valid", out_valid, 1);
    rstn = 1'b0;
    #1;
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_data", out_data, 0);
    chk("t6_rst_last", out_last, 0);
    uq.delete();
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;
    got_q.delete();
    for (int i = 0; i < 4; i++) send(pkt[i], i == 3);
    drain();
    chk("t6_nbeats", got_q.size(), 3);
    for (int i = 0; i < 3 && i < got_q.size(); i++) chk("t6_beat", got_q[i], pkt_exp[i]);

`ifdef RAH_TX_GEARBOX_ERR_EN
    chk("err_clear", err, 0);
    out_ready = 1'b0;
    for (int i = 0; i < 12 && in_ready; i++) send(rnd(), 1'b0);
    chk("err_stalled", in_ready, 0);
    in_valid = 1'b1; in_data = 48'h1234_5678_9ABC; in_last = 1'b0;
    @(posedge clk); #1;
    chk("err_pre", err, 0);
    in_data = 48'hFEDC_BA98_7654;
    @(posedge clk); #1;
    chk("err_set", err, 1);
    in_valid = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("err_sticky", err, 1);
    out_ready = 1'b1;
    do_reset();
    chk("err_reset", err, 0);
`else
    chk("err_tied", err, 0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/rah_tx_gearbox.md
Name: rah_tx_gearbox

Overview:
TX-side width converter, the transmit counterpart of the RX data aligner. Packs a stream of DATA_WIDTH-bit RAH packet words from the RAH encoder into MIPI_WIDTH-bit beats for the MIPI TX DATA bus. Packing is dense: at 48→64, four words fill exactly three beats. It supports a packet-end flush with zero padding and a valid/ready handshake on both sides.

Parameters:
DATA_WIDTH, 48, input word width (RAH packet width); multiple of 16, at most MIPI_WIDTH.
MIPI_WIDTH, 64, output beat width; multiple of 16.

Ports:
clk  input  1  tx pixel clock; all logic is on the rising edge.
rstn  input  1  asynchronous active-low reset.
in_valid  input  1  in_data holds a word.
in_data  input  DATA_WIDTH  RAH packet word.
in_last  input  1  the word is the final word of a packet; the packer flushes after it.
in_ready  output  1  the packer can accept a word this cycle.
out_valid  output  1  out_data holds a beat.
out_data  output  MIPI_WIDTH  packed beat.
out_last  output  1  final beat of a flushed packet.
out_ready  input  1  the sink consumes the beat this cycle.
err  output  1  sticky protocol-error flag (see Optional Feature).

Behaviour:
- Unit of accounting is U = 16 bits. D = DATA_WIDTH/16 (3). M = MIPI_WIDTH/16 (4).
- Accumulator acc is (M+2D)*16 bits (160). The fill count cnt runs 0..M+2D (0..10) and is registered.
- Reset (async, rstn=0): acc=0, cnt=0, flush_pending=0, out_valid=0, out_data=0, out_last=0, err=0.
- in_ready = (cnt <= 2D+M-D, i.e. 7) && !flush_pending.
  - Computed from registers only; there is no combinational path from out_ready to in_ready.
- Accept: the word is accepted on a clock edge where in_valid && in_ready.
- Output register free: out_valid==0 || out_ready==1.
- Pop: occurs on a clock edge when the output register is free and (cnt >= M || (flush_pending && cnt > 0)).
  - out_data ← acc[MIPI_WIDTH-1:0]; units at or above cnt are forced to 0 (zero pad).
  - out_valid ← 1.
  - out_last ← flush_pending && cnt <= M.
  - acc shifts right by MIPI_WIDTH; cnt ← cnt − min(cnt, M).
- Output register free with no pop: out_valid ← 0. out_data and out_last hold their values.
- Push: the accepted word is written at bit offset (cnt_after_pop)*16 and cnt ← cnt_after_pop + D.
  - Push and pop may occur on the same edge. The pop is applied first.
- Ordering: the first word occupies the LSBs. Beat n bit i equals stream bit 64n+i.
- Flush: accepting a word with in_last sets flush_pending.
  - flush_pending clears on the edge that loads the beat with out_last=1; cnt is then 0.
  - in_ready reasserts the following cycle.
- Latency: a pop on edge k+1 follows the edge k that first makes cnt ≥ M; out_valid is visible after edge k+1.
- Throughput: with out_ready=1, in_valid sustains 1 word/clock indefinitely. Steady-state cnt cycles 6→5→4→3→6.
- Backpressure: while out_valid && !out_ready, out_data and out_last are stable.
  - cnt grows to at most 10; in_ready falls once cnt ≥ 8. No data is lost.
- in_last on a word that exactly completes a beat: the last beat has no padding and out_last=1.
- Reset mid-packet: all partial data is discarded. The next packet starts at cnt=0.

Optional Feature:
Macro RAH_TX_GEARBOX_ERR_EN.
- Defined: err sets, and stays set until reset, on any edge where in_valid was high with in_ready low on the previous edge and, on this edge, in_valid is low or in_data/in_last changed. This catches stall-stability violations.
- Undefined: err is tied to 0 and no checking logic is built.

Test Plan:
1. Reset → all outputs 0, in_ready=1 after rstn deasserts.
2. Packet of 4 words w0=48'h0000_1111_2222, w1=48'h3333_4444_5555, w2=48'h6666_7777_8888, w3=48'h9999_AAAA_BBBB sent back-to-back, in_last on w3, out_ready=1 → three beats:
   - 64'h5555_0000_1111_2222
   - 64'h7777_8888_3333_4444
   - 64'h9999_AAAA_BBBB_6666 with out_last=1.
3. Single word 48'hDEAD_BEEF_CAFE with in_last → one beat 64'h0000_DEAD_BEEF_CAFE, out_last=1. in_ready is low until that beat is loaded.
4. Streaming 1000 words, out_ready=1 → in_ready never drops and exactly 750 beats are produced, matching the scoreboard.
5. Streaming with out_ready=0 for 10 cycles mid-stream → out_data is stable during the stall, in_ready falls at cnt ≥ 8, and the data order is intact after release.
6. rstn pulsed low mid-packet → outputs clear the same cycle; the next 4-word packet reproduces the expected values from test 2 exactly.
   - With RAH_TX_GEARBOX_ERR_EN defined, additionally: change in_data while stalled → err=1 and it stays set.
